beta_prefetch_buffer: RTL and testbench

BETA_PREFETCH_BUFFER -- requirements
Module: beta_prefetch_buffer

---
 rtl/beta_if_stage_pkg.sv | 20 ++
 rtl/beta_pfb_fifo.sv | 74 +++++++
 rtl/beta_prefetch_buffer.sv | 117 +++++++++++
 tb/tb_beta_prefetch_buffer.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/beta_if_stage_pkg.sv
// Shared IF-stage types: IMEM and prefetch-buffer FSM state encodings.
package beta_if_stage_pkg;

    localparam int imem_fsm_bsize = 2;

    typedef enum logic [imem_fsm_bsize-1:0] {
        IMEM_IDLE = 2'b00,
        IMEM_REQ  = 2'b01,
        IMEM_WAIT = 2'b10
    } imem_state_e;

    localparam int pfb_fsm_bsize = 2;

    typedef enum logic [pfb_fsm_bsize-1:0] {
        PFB_IDLE  = 2'b00,
        PFB_RUN   = 2'b01,
        PFB_FLUSH = 2'b10
    } pfb_state_e;

endpackage

// File: rtl/beta_pfb_fifo.sv
// Prefetch-buffer storage: circular array of {instr, pc} entries with count,
// synchronous clear and full/empty flags.
module beta_pfb_fifo #(
    parameter int Width = 64,
    parameter int Depth = 4
) (
    input  logic                     clk_i,
    input  logic                     rstn_i,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  logic [Width-1:0]         wdata,
    output logic [Width-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(Depth):0]   count
);

    localparam int PtrW = $clog2(Depth);
    localparam int CntW = PtrW + 1;

    logic [Width-1:0] r_mem [Depth];
    logic [PtrW-1:0]  r_wr_ptr;
    logic [PtrW-1:0]  r_rd_ptr;
    logic [CntW-1:0]  r_count;
    logic             w_wr;
    logic             w_rd;

    assign full  = (r_count == CntW'(Depth));
    assign empty = (r_count == '0);
    assign count = r_count;
    assign rdata = r_mem[r_rd_ptr];

    // A full buffer still accepts a write when the head leaves in the same cycle
    assign w_rd = pop && !empty;
    assign w_wr = push && (!full || w_rd);

    // Entry storage; cleared only by reset so stale data never reads as X
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < Depth; i++) begin
                r_mem[i] <= '0;
            end
        end else if (!clear && w_wr) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

    // Pointers and occupancy; clear dominates any same-cycle push or pop
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + PtrW'(1);
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + PtrW'(1);
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + CntW'(1);
                2'b01:   r_count <= r_count - CntW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/beta_prefetch_buffer.sv
// Instruction prefetch buffer: one fetch in flight, flush/redirect handling.
// Optional same-cycle bypass of an empty buffer under BETA_PFB_BYPASS_EN.
module beta_prefetch_buffer
    import beta_if_stage_pkg::*;
#(
    parameter int                   DataWidth = 32,
    parameter int                   Depth     = 4,
    parameter logic [DataWidth-1:0] BootAddr  = 32'h0000_0000
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 pfb_en_i,
    input  logic                 pfb_flush_i,
    input  logic [DataWidth-1:0] pfb_flush_addr_i,
    output logic                 pfb_fu_fetch_en_o,
    output logic [DataWidth-1:0] pfb_fu_addr_o,
    input  logic                 pfb_fu_new_instr_i,
    input  logic [DataWidth-1:0] pfb_fu_instr_i,
    output logic                 pfb_valid_o,
    output logic [DataWidth-1:0] pfb_instr_o,
    output logic [DataWidth-1:0] pfb_pc_o,
    input  logic                 pfb_ready_i
);

    localparam int                   CntW     = $clog2(Depth) + 1;
    localparam logic [CntW:0]        DepthLim = (CntW + 1)'(Depth);
    localparam logic [DataWidth-1:0] AddrStep = DataWidth'(4);

    pfb_state_e           r_state;
    logic                 r_outstanding;
    logic [DataWidth-1:0] r_fetch_addr;
    logic [DataWidth-1:0] r_req_pc;

    logic [CntW-1:0]      w_count;
    logic [CntW:0]        w_inflight;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_fetch_en;
    logic                 w_push;
    logic                 w_fifo_push;
    logic                 w_pop;
    logic [DataWidth-1:0] w_head_instr;
    logic [DataWidth-1:0] w_head_pc;

    assign w_inflight = {1'b0, w_count} + {{CntW{1'b0}}, r_outstanding};
    assign w_fetch_en = (r_state == PFB_RUN) && !r_outstanding && !w_full
                        && (w_inflight < DepthLim) && !pfb_flush_i;

    assign pfb_fu_fetch_en_o = w_fetch_en;
    assign pfb_fu_addr_o     = r_fetch_addr;

    // Returns arriving in PFB_FLUSH, or alongside a flush, belong to the old stream
    assign w_push = (r_state == PFB_RUN) && pfb_fu_new_instr_i && !pfb_flush_i;
    assign w_pop  = !w_empty && pfb_ready_i && !pfb_flush_i;

`ifdef BETA_PFB_BYPASS_EN
    logic w_bypass;
    assign w_bypass    = w_push && w_empty;
    assign w_fifo_push = w_push && !(w_bypass && pfb_ready_i);
    assign pfb_valid_o = !w_empty || w_bypass;
    assign pfb_instr_o = w_bypass ? pfb_fu_instr_i : w_head_instr;
    assign pfb_pc_o    = w_bypass ? r_req_pc : w_head_pc;
`else
    assign w_fifo_push = w_push;
    assign pfb_valid_o = !w_empty;
    assign pfb_instr_o = w_head_instr;
    assign pfb_pc_o    = w_head_pc;
`endif

    // Control FSM, in-flight flag, fetch address and the PC tagged to the pending request
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            r_state       <= PFB_IDLE;
            r_outstanding <= 1'b0;
            r_fetch_addr  <= BootAddr;
            r_req_pc      <= '0;
        end else begin
            case (r_state)
                PFB_IDLE:  r_state <= pfb_en_i ? PFB_RUN : PFB_IDLE;
                PFB_RUN:   r_state <= (pfb_flush_i && r_outstanding && !pfb_fu_new_instr_i)
                                      ? PFB_FLUSH : PFB_RUN;
                PFB_FLUSH: r_state <= pfb_fu_new_instr_i ? PFB_RUN : PFB_FLUSH;
                default:   r_state <= PFB_IDLE;
            endcase

            if (w_fetch_en) begin
                r_outstanding <= 1'b1;
                r_req_pc      <= r_fetch_addr;
            end else if (pfb_fu_new_instr_i) begin
                r_outstanding <= 1'b0;
            end

            if (pfb_flush_i) begin
                r_fetch_addr <= pfb_flush_addr_i;
            end else if (w_fetch_en) begin
                r_fetch_addr <= r_fetch_addr + AddrStep;
            end
        end
    end

    beta_pfb_fifo #(
        .Width (2 * DataWidth),
        .Depth (Depth)
    ) u_fifo (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .clear  (pfb_flush_i),
        .push   (w_fifo_push),
        .pop    (w_pop),
        .wdata  ({pfb_fu_instr_i, r_req_pc}),
        .rdata  ({w_head_instr, w_head_pc}),
        .full   (w_full),
        .empty  (w_empty),
        .count  (w_count)
    );

endmodule

// File: tb/tb_beta_prefetch_buffer.sv
// Self-checking bench for beta_prefetch_buffer: directed scenarios plus
// randomized traffic against a queue-based reference model.
module tb_beta_prefetch_buffer;

    localparam int          DEPTH = 4;
    localparam logic [31:0] BOOT  = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;

    logic        clk_i = 1'b0;
    logic        rstn_i = 1'b0;
    logic        pfb_en_i = 1'b0;
    logic        pfb_flush_i = 1'b0;
    logic [31:0] pfb_flush_addr_i = '0;
    logic        pfb_fu_fetch_en_o;
    logic [31:0] pfb_fu_addr_o;
    logic        pfb_fu_new_instr_i = 1'b0;
    logic [31:0] pfb_fu_instr_i = '0;
    logic        pfb_valid_o;
    logic [31:0] pfb_instr_o;
    logic [31:0] pfb_pc_o;
    logic        pfb_ready_i = 1'b0;

    beta_prefetch_buffer #(
        .DataWidth (32),
        .Depth     (DEPTH),
        .BootAddr  (BOOT)
    ) dut (
        .clk_i              (clk_i),
        .rstn_i             (rstn_i),
        .pfb_en_i           (pfb_en_i),
        .pfb_flush_i        (pfb_flush_i),
        .pfb_flush_addr_i   (pfb_flush_addr_i),
        .pfb_fu_fetch_en_o  (pfb_fu_fetch_en_o),
        .pfb_fu_addr_o      (pfb_fu_addr_o),
        .pfb_fu_new_instr_i (pfb_fu_new_instr_i),
        .pfb_fu_instr_i     (pfb_fu_instr_i),
        .pfb_valid_o        (pfb_valid_o),
        .pfb_instr_o        (pfb_instr_o),
        .pfb_pc_o           (pfb_pc_o),
        .pfb_ready_i        (pfb_ready_i)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    bit          m_run;
    bit          m_drop;
    bit          m_out;
    logic [31:0] m_addr;
    ent_t        m_q[$];
    int          fu_cnt;
    int          fu_lat = 3;
    logic [31:0] fu_pc;
    logic [31:0] issued[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rstn_i = 1'b0;
        pfb_en_i = 1'b0;
        pfb_flush_i = 1'b0;
        pfb_flush_addr_i = '0;
        pfb_fu_new_instr_i = 1'b0;
        pfb_fu_instr_i = '0;
        pfb_ready_i = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        rstn_i = 1'b1;
        m_run = 1'b0;
        m_drop = 1'b0;
        m_out = 1'b0;
        m_addr = BOOT;
        m_q.delete();
        fu_cnt = 0;
    endtask

    // One clock: drive inputs, compare outputs with the model, advance the model
    task automatic cycle(input bit en, input bit flush, input logic [31:0] faddr, input bit ready);
        bit          newi;
        bit          fe;
        bit          push_ok;
        bit          byp;
        bit          pop;
        logic        exp_v;
        logic [31:0] instr;
        ent_t        e;
        @(negedge clk_i);
        newi = (fu_cnt == 1);
        if (fu_cnt > 0) fu_cnt--;
        instr = $urandom();
        pfb_en_i = en;
        pfb_flush_i = flush;
        pfb_flush_addr_i = faddr;
        pfb_fu_new_instr_i = newi;
        pfb_fu_instr_i = newi ? instr : 32'h0;
        pfb_ready_i = ready;
        #1;
        fe = m_run && !m_drop && !m_out && (m_q.size() < DEPTH) && !flush;
        push_ok = m_run && !m_drop && newi && !flush;
`ifdef BETA_PFB_BYPASS_EN
        byp = push_ok && (m_q.size() == 0);
`else
        byp = 1'b0;
`endif
        exp_v = (m_q.size() > 0) || byp;
        chk("fetch_en", {31'b0, pfb_fu_fetch_en_o}, {31'b0, fe});
        chk("fetch_addr", pfb_fu_addr_o, m_addr);
        chk("valid", {31'b0, pfb_valid_o}, {31'b0, exp_v});
        if (m_q.size() > 0) begin
            chk("head_instr", pfb_instr_o, m_q[0].instr);
            chk("head_pc", pfb_pc_o, m_q[0].pc);
        end else if (byp) begin
            chk("bypass_instr", pfb_instr_o, instr);
            chk("bypass_pc", pfb_pc_o, fu_pc);
        end
        if (pfb_fu_fetch_en_o) issued.push_back(pfb_fu_addr_o);

        pop = (m_q.size() > 0) && ready && !flush;
        if (flush) begin
            m_q.delete();
        end else begin
            if (pop) void'(m_q.pop_front());
            if (push_ok && !(byp && ready)) begin
                e.instr = instr;
                e.pc = fu_pc;
                m_q.push_back(e);
            end
        end
        if (m_drop && newi) m_drop = 1'b0;
        else if (m_run && !m_drop && flush && m_out && !newi) m_drop = 1'b1;
        if (fe) m_out = 1'b1;
        else if (newi) m_out = 1'b0;
        if (fe) begin
            fu_pc = m_addr;
            fu_cnt = fu_lat;
        end
        if (flush) m_addr = faddr;
        else if (fe) m_addr = m_addr + 32'd4;
        if (!m_run && en) m_run = 1'b1;
    endtask

    function automatic logic [31:0] issued_at(input int idx);
        return (issued.size() > idx) ? issued[idx] : 32'hDEAD_BEEF;
    endfunction

    initial begin
        do_reset();
        #1;
        chk("rst_fetch_en", {31'b0, pfb_fu_fetch_en_o}, 32'h0);
        chk("rst_valid", {31'b0, pfb_valid_o}, 32'h0);
        chk("rst_instr", pfb_instr_o, 32'h0);
        chk("rst_pc", pfb_pc_o, 32'h0);
        chk("rst_addr", pfb_fu_addr_o, BOOT);

        // Fill with latency 3, nothing consumed
        fu_lat = 3;
        issued.delete();
        for (int i = 0; i < 30; i++) cycle(1'b1, 1'b0, 32'h0, 1'b0);
        chk("fill_count", issued.size(), 32'd4);
        chk("fill_addr0", issued_at(0), 32'h0);
        chk("fill_addr1", issued_at(1), 32'h4);
        chk("fill_addr2", issued_at(2), 32'h8);
        chk("fill_addr3", issued_at(3), 32'hC);
        cycle(1'b1, 1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 32'h0, 1'b0);
        chk("refill_count", issued.size(), 32'd5);
        chk("refill_addr", issued_at(4), 32'h10);

        // Flush while a fetch is outstanding
        for (int i = 0; i < 60 && fu_cnt != 3; i++) cycle(1'b1, 1'b0, 32'h0, 1'b1);
        chk("flush1_setup", fu_cnt, 32'd3);
        issued.delete();
        cycle(1'b1, 1'b1, 32'h100, 1'b1);
        for (int i = 0; i < 12; i++) cycle(1'b1, 1'b0, 32'h0, 1'b1);
        chk("flush1_next_addr", issued_at(0), 32'h100);

        // Flush coinciding with the return of the in-flight instruction
        for (int i = 0; i < 60 && fu_cnt != 1; i++) cycle(1'b1, 1'b0, 32'h0, 1'b1);
        chk("flush2_setup", fu_cnt, 32'd1);
        issued.delete();
        cycle(1'b1, 1'b1, 32'h200, 1'b1);
        for (int i = 0; i < 12; i++) cycle(1'b1, 1'b0, 32'h0, 1'b1);
        chk("flush2_next_addr", issued_at(0), 32'h200);

        // Randomized traffic with occasional flushes and resets
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
            end else begin
                fu_lat = $urandom_range(1, 4);
                cycle($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0,
                      $urandom() & 32'hFFFF_FFFC, $urandom_range(0, 1) == 1);
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
